// File: rtl/dmem_pkg.sv
// Shared widths, ownership encoding and byte-to-word address helper for the
// DataMemory arbiter.
package dmem_pkg;

   localparam int unsigned DMEM_ADDR_W = 6;
   localparam int unsigned DMEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_t;

   function automatic logic [DMEM_ADDR_W-1:0] byte_to_word(input logic [31:0] addr);
      logic unused_bits;
      unused_bits = ^{addr[31:8], addr[1:0]};
      return addr[7:2];
   endfunction

endpackage

// File: rtl/dmem_rr_select.sv
// Combinational winner pick: a single requester wins outright; on contention a
// locked owner keeps the slot until its hold budget runs out, else round-robin.
module dmem_rr_select
   import dmem_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4,
   parameter int unsigned HOLD_W   = 3
) (
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              lock0_i,
   input  logic              lock1_i,
   input  owner_t            owner_i,
   input  logic              last_i,
   input  logic [HOLD_W-1:0] hold_cnt_i,
   output logic              gnt0_o,
   output logic              gnt1_o
);

   localparam logic [HOLD_W-1:0] MaxHold = HOLD_W'(MAX_HOLD);

   logic owner_locked;

   assign owner_locked = ((owner_i == OWN0) && lock0_i) || ((owner_i == OWN1) && lock1_i);

   always_comb begin
      gnt0_o = req0_i & ~req1_i;
      gnt1_o = req1_i & ~req0_i;
      if (req0_i && req1_i) begin
         if (owner_locked && (hold_cnt_i < MaxHold)) begin
            gnt0_o = (owner_i == OWN0);
            gnt1_o = (owner_i == OWN1);
         end else begin
            // last_i = 1 means port 1 was served last, so port 0 is next
            gnt0_o = last_i;
            gnt1_o = ~last_i;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded locking in front of DataMemory.
// Optional address range checking: define DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W   = DMEM_ADDR_W,
   parameter int unsigned DATA_W   = DMEM_DATA_W,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic              Clock,
   input  logic              ResetN,
   input  logic              Req0,
   input  logic              Req1,
   input  logic              We0,
   input  logic              We1,
   input  logic [31:0]       Addr0,
   input  logic [31:0]       Addr1,
   input  logic [DATA_W-1:0] WData0,
   input  logic [DATA_W-1:0] WData1,
   input  logic              Lock0,
   input  logic              Lock1,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              RValid0,
   output logic              RValid1,
   output logic [DATA_W-1:0] RData0,
   output logic [DATA_W-1:0] RData1,
   output logic              Err0,
   output logic              Err1,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] WriteData,
   output logic              MemoryRead,
   output logic              MemoryWrite,
   input  logic [DATA_W-1:0] ReadData
);

   localparam int unsigned       HOLD_W  = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] MaxHold = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

   owner_t            state_q, state_d;
   logic              last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic              err0_q, err0_d, err1_q, err1_d;

   logic              sel0, sel1, grant_any, addr_bad, access;
   logic              sel_we, sel_lock;
   logic [31:0]       sel_addr;

   dmem_rr_select #(
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) u_select (
      .req0_i     (Req0),
      .req1_i     (Req1),
      .lock0_i    (Lock0),
      .lock1_i    (Lock1),
      .owner_i    (state_q),
      .last_i     (last_q),
      .hold_cnt_i (hold_q),
      .gnt0_o     (sel0),
      .gnt1_o     (sel1)
   );

   assign Gnt0      = sel0 & ResetN;
   assign Gnt1      = sel1 & ResetN;
   assign grant_any = Gnt0 | Gnt1;

   assign sel_we    = Gnt1 ? We1   : We0;
   assign sel_lock  = Gnt1 ? Lock1 : Lock0;
   assign sel_addr  = Gnt1 ? Addr1 : Addr0;

`ifdef DMEM_ARB_RANGE_CHECK_EN
   assign addr_bad = (sel_addr[31:8] != '0) || (sel_addr[1:0] != '0);
`else
   assign addr_bad = 1'b0;
`endif

   assign access      = grant_any & ~addr_bad;
   assign MemAddress  = ADDR_W'(byte_to_word(sel_addr));
   assign WriteData   = Gnt1 ? WData1 : WData0;
   assign MemoryWrite = access & sel_we;
   assign MemoryRead  = access & ~sel_we;

   always_comb begin
      state_d   = IDLE;
      last_d    = last_q;
      hold_d    = '0;
      rvalid0_d = Gnt0 & ~We0 & ~addr_bad;
      rvalid1_d = Gnt1 & ~We1 & ~addr_bad;
      err0_d    = Gnt0 & addr_bad;
      err1_d    = Gnt1 & addr_bad;
      if (grant_any) begin
         state_d = Gnt1 ? OWN1 : OWN0;
         last_d  = Gnt1;
         // Hold budget only accrues while the winner keeps Lock asserted
         if (sel_lock) begin
            if (state_d != state_q) begin
               hold_d = HoldOne;
            end else if (hold_q < MaxHold) begin
               hold_d = hold_q + HoldOne;
            end else begin
               hold_d = hold_q;
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         hold_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
      end
   end

   assign RValid0 = rvalid0_q;
   assign RValid1 = rvalid1_q;
   assign RData0  = rvalid0_q ? ReadData : '0;
   assign RData1  = rvalid1_q ? ReadData : '0;
   assign Err0    = err0_q;
   assign Err1    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a rule-level arbitration and shadow-memory model.
module tb_dmem_arbiter;

   localparam int MAXH = 4;

   logic        Clock = 1'b0;
   logic        ResetN = 1'b0;
   logic        Req0, Req1, We0, We1, Lock0, Lock1;
   logic [31:0] Addr0, Addr1, WData0, WData1;
   logic        Gnt0, Gnt1, RValid0, RValid1, Err0, Err1;
   logic [31:0] RData0, RData1;
   logic [5:0]  MemAddress;
   logic [31:0] WriteData;
   logic        MemoryRead, MemoryWrite;
   logic [31:0] ReadData;

   logic [31:0] mem [64];
   logic [31:0] shadow [64];

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   dmem_arbiter #(
      .ADDR_W   (6),
      .DATA_W   (32),
      .MAX_HOLD (MAXH)
   ) dut (
      .Clock       (Clock),
      .ResetN      (ResetN),
      .Req0        (Req0),
      .Req1        (Req1),
      .We0         (We0),
      .We1         (We1),
      .Addr0       (Addr0),
      .Addr1       (Addr1),
      .WData0      (WData0),
      .WData1      (WData1),
      .Lock0       (Lock0),
      .Lock1       (Lock1),
      .Gnt0        (Gnt0),
      .Gnt1        (Gnt1),
      .RValid0     (RValid0),
      .RValid1     (RValid1),
      .RData0      (RData0),
      .RData1      (RData1),
      .Err0        (Err0),
      .Err1        (Err1),
      .MemAddress  (MemAddress),
      .WriteData   (WriteData),
      .MemoryRead  (MemoryRead),
      .MemoryWrite (MemoryWrite),
      .ReadData    (ReadData)
   );

   // Single-ported 64x32 memory with one-cycle read latency and no reset
   always @(posedge Clock) begin
      if (MemoryWrite) mem[MemAddress] <= WriteData;
      if (MemoryRead)  ReadData <= mem[MemAddress];
   end

   task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic l);
      Req0 = r; We0 = w; Addr0 = a; WData0 = d; Lock0 = l;
   endtask

   task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic l);
      Req1 = r; We1 = w; Addr1 = a; WData1 = d; Lock1 = l;
   endtask

   task automatic idle();
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic apply_reset();
      ResetN = 1'b0;
      idle();
      repeat (2) @(posedge Clock);
      #1;
      ResetN = 1'b1;
   endtask

   task automatic clear_memory();
      apply_reset();
      for (int i = 0; i < 64; i++) begin
         drive1(1'b1, 1'b1, 32'(i * 4), 32'h0, 1'b0);
         shadow[i] = 32'h0;
         next_cycle();
      end
      idle();
      next_cycle();
   endtask

   task automatic test_reset();
      idle();
      next_cycle();
      drive0(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      drive1(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      #1;
      checks++; if (Gnt0 !== 1'b0 || Gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b exp 00", Gnt0, Gnt1); end
      checks++; if (MemoryRead !== 1'b0 || MemoryWrite !== 1'b0) begin errors++; $display("FAIL reset_strobe: got rd=%b wr=%b exp 0 0", MemoryRead, MemoryWrite); end
      checks++; if ({RValid0, RValid1, Err0, Err1} !== 4'b0000) begin errors++; $display("FAIL reset_regs: got %b exp 0000", {RValid0, RValid1, Err0, Err1}); end
      @(posedge Clock);
      #1;
      ResetN = 1'b1;
      #1;
      checks++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin errors++; $display("FAIL reset_first_tie: got %b%b exp 10", Gnt0, Gnt1); end
      idle();
      next_cycle();
   endtask

   task automatic test_write_read();
      apply_reset();
      drive1(1'b1, 1'b1, 32'hc8, 32'haaaaffff, 1'b0);
      #1;
      checks++; if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0) begin errors++; $display("FAIL wr_gnt: got %b%b exp 01", Gnt0, Gnt1); end
      checks++; if (MemoryWrite !== 1'b1 || MemoryRead !== 1'b0) begin errors++; $display("FAIL wr_strobe: got rd=%b wr=%b exp 0 1", MemoryRead, MemoryWrite); end
      checks++; if (MemAddress !== 6'h32 || WriteData !== 32'haaaaffff) begin errors++; $display("FAIL wr_port: got %h/%h exp 32/aaaaffff", MemAddress, WriteData); end
      shadow[50] = 32'haaaaffff;
      next_cycle();
      drive1(1'b1, 1'b0, 32'hc8, 32'h0, 1'b0);
      #1;
      checks++; if (Gnt1 !== 1'b1 || MemoryRead !== 1'b1) begin errors++; $display("FAIL rd_gnt: got gnt1=%b rd=%b exp 1 1", Gnt1, MemoryRead); end
      next_cycle();
      idle();
      #1;
      checks++; if (RValid1 !== 1'b1 || RData1 !== 32'haaaaffff || RValid0 !== 1'b0) begin errors++; $display("FAIL rd_data: got v=%b d=%h v0=%b exp 1 aaaaffff 0", RValid1, RData1, RValid0); end
      next_cycle();
      checks++; if (RValid1 !== 1'b0 || RData1 !== 32'h0) begin errors++; $display("FAIL rd_pulse_end: got v=%b d=%h exp 0 0", RValid1, RData1); end
   endtask

   task automatic test_tie_read();
      apply_reset();
      drive1(1'b1, 1'b1, 32'hf0, 32'hffff0000, 1'b0);
      next_cycle();
      idle();
      drive0(1'b1, 1'b1, 32'h14, 32'h0, 1'b0);
      next_cycle();
      shadow[60] = 32'hffff0000;
      shadow[5]  = 32'h0;
      apply_reset();
      drive0(1'b1, 1'b0, 32'h14, 32'h0, 1'b0);
      drive1(1'b1, 1'b0, 32'hf0, 32'h0, 1'b0);
      #1;
      checks++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0 || MemAddress !== 6'h05) begin errors++; $display("FAIL tie_first: got %b%b addr=%h exp 10 05", Gnt0, Gnt1, MemAddress); end
      next_cycle();
      drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      checks++; if (RValid0 !== 1'b1 || RData0 !== 32'h0) begin errors++; $display("FAIL tie_rdata0: got v=%b d=%h exp 1 0", RValid0, RData0); end
      checks++; if (Gnt1 !== 1'b1 || MemAddress !== 6'h3c) begin errors++; $display("FAIL tie_second: got gnt1=%b addr=%h exp 1 3c", Gnt1, MemAddress); end
      next_cycle();
      idle();
      #1;
      checks++; if (RValid1 !== 1'b1 || RData1 !== 32'hffff0000 || RValid0 !== 1'b0) begin errors++; $display("FAIL tie_rdata1: got v=%b d=%h v0=%b exp 1 ffff0000 0", RValid1, RData1, RValid0); end
      next_cycle();
   endtask

   task automatic test_alternate();
      int expw;
      apply_reset();
      drive0(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
      drive1(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
      expw = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         checks++; if (Gnt0 !== (expw == 0) || Gnt1 !== (expw == 1)) begin errors++; $display("FAIL alternate c%0d: got %b%b exp port %0d", c, Gnt0, Gnt1, expw); end
         next_cycle();
         expw = 1 - expw;
      end
      idle();
      next_cycle();
   endtask

   task automatic test_lock();
      apply_reset();
      drive0(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
      drive1(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      for (int c = 0; c <= MAXH; c++) begin
         #1;
         checks++; if (Gnt0 !== (c < MAXH) || Gnt1 !== (c == MAXH)) begin errors++; $display("FAIL lock c%0d: got %b%b exp %b%b", c, Gnt0, Gnt1, c < MAXH, c == MAXH); end
         next_cycle();
      end
      idle();
      next_cycle();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive0(1'b1, 1'b0, 32'hc8, 32'h0, 1'b0);
      #1;
      checks++; if (Gnt0 !== 1'b1 || MemoryRead !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got gnt0=%b rd=%b exp 1 1", Gnt0, MemoryRead); end
      next_cycle();
      idle();
      #1;
      checks++; if (RValid0 !== 1'b1 || RData0 !== 32'haaaaffff) begin errors++; $display("FAIL rstmid_pre: got v=%b d=%h exp 1 aaaaffff", RValid0, RData0); end
      drive0(1'b1, 1'b0, 32'h14, 32'h0, 1'b0);
      drive1(1'b1, 1'b0, 32'hf0, 32'h0, 1'b0);
      ResetN = 1'b0;
      #1;
      checks++; if (RValid0 !== 1'b0 || RData0 !== 32'h0) begin errors++; $display("FAIL rstmid_rvalid: got v=%b d=%h exp 0 0", RValid0, RData0); end
      checks++; if (Gnt0 !== 1'b0 || Gnt1 !== 1'b0 || MemoryRead !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got %b%b rd=%b exp 00 0", Gnt0, Gnt1, MemoryRead); end
      @(posedge Clock);
      #1;
      ResetN = 1'b1;
      #1;
      checks++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin errors++; $display("FAIL rstmid_tie: got %b%b exp 10", Gnt0, Gnt1); end
      idle();
      next_cycle();
   endtask

`ifdef DMEM_ARB_RANGE_CHECK_EN
   task automatic test_range();
      apply_reset();
      drive0(1'b1, 1'b0, 32'h102, 32'h0, 1'b0);
      #1;
      checks++; if (Gnt0 !== 1'b1 || MemoryRead !== 1'b0 || MemoryWrite !== 1'b0) begin errors++; $display("FAIL range_grant: got gnt0=%b rd=%b wr=%b exp 1 0 0", Gnt0, MemoryRead, MemoryWrite); end
      next_cycle();
      idle();
      #1;
      checks++; if (Err0 !== 1'b1 || RValid0 !== 1'b0) begin errors++; $display("FAIL range_err: got err=%b v=%b exp 1 0", Err0, RValid0); end
      next_cycle();
      checks++; if (Err0 !== 1'b0) begin errors++; $display("FAIL range_err_end: got %b exp 0", Err0); end
   endtask
`endif

   task automatic test_random();
      bit          pend [2];
      logic        we [2];
      logic        lk [2];
      logic [31:0] addr [2];
      logic [31:0] data [2];
      bit          erv [2];
      bit          eerr [2];
      logic [31:0] erd [2];
      int          owner, last, run, w, idx;
      bit          bad;
      apply_reset();
      owner = -1; last = 1; run = 0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; erv[p] = 0; eerr[p] = 0; erd[p] = 32'h0;
         we[p] = 1'b0; lk[p] = 1'b0; addr[p] = 32'h0; data[p] = 32'h0;
      end
      for (int c = 0; c < 400; c++) begin
         checks++; if (RValid0 !== erv[0] || RData0 !== (erv[0] ? erd[0] : 32'h0)) begin errors++; $display("FAIL rand_r0 c%0d: got v=%b d=%h exp v=%b d=%h", c, RValid0, RData0, erv[0], erd[0]); end
         checks++; if (RValid1 !== erv[1] || RData1 !== (erv[1] ? erd[1] : 32'h0)) begin errors++; $display("FAIL rand_r1 c%0d: got v=%b d=%h exp v=%b d=%h", c, RValid1, RData1, erv[1], erd[1]); end
         checks++; if (Err0 !== eerr[0] || Err1 !== eerr[1]) begin errors++; $display("FAIL rand_err c%0d: got %b%b exp %b%b", c, Err0, Err1, eerr[0], eerr[1]); end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 9) < 6) begin
               pend[p] = 1;
               we[p]   = 1'($urandom_range(0, 1));
               lk[p]   = ($urandom_range(0, 3) != 0);
               addr[p] = $urandom_range(0, 63) << 2;
`ifdef DMEM_ARB_RANGE_CHECK_EN
               if ($urandom_range(0, 7) == 0) addr[p] = $urandom;
`endif
               data[p] = $urandom;
            end
         end
         drive0(pend[0], we[0], addr[0], data[0], lk[0]);
         drive1(pend[1], we[1], addr[1], data[1], lk[1]);
         #1;
         if (pend[0] && pend[1]) w = (owner >= 0 && lk[owner] && run < MAXH) ? owner : 1 - last;
         else if (pend[0]) w = 0;
         else if (pend[1]) w = 1;
         else w = -1;
         checks++; if (Gnt0 !== (w == 0) || Gnt1 !== (w == 1)) begin errors++; $display("FAIL rand_gnt c%0d: got %b%b exp winner %0d", c, Gnt0, Gnt1, w); end
         erv[0] = 0; erv[1] = 0; eerr[0] = 0; eerr[1] = 0;
         if (w < 0) begin
            checks++; if (MemoryRead !== 1'b0 || MemoryWrite !== 1'b0) begin errors++; $display("FAIL rand_idle c%0d: got rd=%b wr=%b exp 0 0", c, MemoryRead, MemoryWrite); end
            owner = -1; run = 0;
         end else begin
`ifdef DMEM_ARB_RANGE_CHECK_EN
            bad = (addr[w] > 32'hff) || (addr[w] % 4 != 0);
`else
            bad = 0;
`endif
            idx = int'(addr[w][7:2]);
            checks++; if (MemoryRead !== (!we[w] && !bad) || MemoryWrite !== (we[w] && !bad)) begin errors++; $display("FAIL rand_strobe c%0d: got rd=%b wr=%b exp rd=%b wr=%b", c, MemoryRead, MemoryWrite, !we[w] && !bad, we[w] && !bad); end
            if (!bad) begin
               checks++; if (MemAddress !== 6'(idx)) begin errors++; $display("FAIL rand_addr c%0d: got %h exp %h", c, MemAddress, 6'(idx)); end
            end
            if (bad) eerr[w] = 1;
            else if (we[w]) begin
               checks++; if (WriteData !== data[w]) begin errors++; $display("FAIL rand_wdata c%0d: got %h exp %h", c, WriteData, data[w]); end
               shadow[idx] = data[w];
            end else begin
               erv[w] = 1; erd[w] = shadow[idx];
            end
            if (!lk[w]) run = 0;
            else if (w != owner) run = 1;
            else run = (run + 1 > MAXH) ? MAXH : run + 1;
            owner = w; last = w; pend[w] = 0;
         end
         next_cycle();
      end
      idle();
      next_cycle();
   endtask

   initial begin
      idle();
      test_reset();
      clear_memory();
      test_write_read();
      test_tie_read();
      test_alternate();
      test_lock();
      test_reset_mid();
`ifdef DMEM_ARB_RANGE_CHECK_EN
      test_range();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
